// File: rtl/box_readback20.sv
// box_readback20: scans a BOX x BOX framebuffer region and counts pixels that differ from the background.
// Define BOX_READBACK_FIRST_HIT_EN to capture the coordinates of the first differing pixel.
module box_readback20 #(
    parameter int BOX   = 20,
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic [9:0]  x0,
    input  logic [8:0]  y0,
    input  logic [8:0]  bg_color,
    output logic [16:0] mem_addr,
    output logic        mem_rd,
    input  logic [8:0]  mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        occupied,
    output logic [8:0]  hit_count,
    output logic [9:0]  first_x,
    output logic [8:0]  first_y
);
    localparam int CW = $clog2(BOX);
    localparam logic [CW-1:0] LAST = CW'(BOX - 1);
    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [9:0]  V_LIM = 10'(V_RES);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cx, r_cy;
    logic [9:0]    r_x0;
    logic [8:0]    r_y0, r_bg, r_hits;
    logic          r_pend, r_occ;
    logic [10:0]   w_xs;
    logic [9:0]    w_ys;
    logic          w_on, w_rd, w_hit, w_accept, w_last;
    logic [16:0]   w_addr;

    assign w_xs     = 11'(r_x0) + 11'(r_cx);
    assign w_ys     = 10'(r_y0) + 10'(r_cy);
    assign w_on     = (w_xs < H_LIM) && (w_ys < V_LIM);
    assign w_addr   = 17'(w_ys) * 17'(H_RES) + 17'(w_xs);
    assign w_rd     = (r_state == READ) && w_on;
    assign w_hit    = r_pend && (mem_rdata != r_bg);
    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_cx == LAST) && (r_cy == LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? READ : IDLE;
            READ:    w_next = w_last ? DRAIN : READ;
            DRAIN:   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // r_pend marks that mem_rdata this cycle answers last cycle's read
    always_ff @(posedge CLOCK_50) begin
        if (resetn) begin
            r_state <= IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_bg    <= '0;
            r_pend  <= 1'b0;
            r_occ   <= 1'b0;
            r_hits  <= '0;
        end else begin
            r_state <= w_next;
            r_pend  <= w_rd;
            if (w_accept) begin
                r_x0   <= x0;
                r_y0   <= y0;
                r_bg   <= bg_color;
                r_cx   <= '0;
                r_cy   <= '0;
                r_hits <= '0;
                r_occ  <= 1'b0;
            end else if (w_hit) begin
                r_hits <= r_hits + 9'd1;
                r_occ  <= 1'b1;
            end
            if (r_state == READ) begin
                r_cx <= (r_cx == LAST) ? '0 : r_cx + 1'b1;
                if (r_cx == LAST)
                    r_cy <= r_cy + 1'b1;
            end
        end
    end

`ifdef BOX_READBACK_FIRST_HIT_EN
    logic [9:0] r_px, r_fx;
    logic [8:0] r_py, r_fy;

    // coordinates trail the read by one cycle to line up with mem_rdata
    always_ff @(posedge CLOCK_50) begin
        if (resetn) begin
            r_px <= '0;
            r_py <= '0;
            r_fx <= '0;
            r_fy <= '0;
        end else begin
            r_px <= w_xs[9:0];
            r_py <= w_ys[8:0];
            if (w_accept) begin
                r_fx <= '0;
                r_fy <= '0;
            end else if (w_hit && !r_occ) begin
                r_fx <= r_px;
                r_fy <= r_py;
            end
        end
    end

    assign first_x = r_fx;
    assign first_y = r_fy;
`else
    assign first_x = '0;
    assign first_y = '0;
`endif

    assign mem_rd    = w_rd;
    assign mem_addr  = w_rd ? w_addr : '0;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
    assign occupied  = r_occ;
    assign hit_count = r_hits;
endmodule

// File: tb/tb_box_readback20.sv
// tb_box_readback20: directed scans against a framebuffer model with per-cycle output checking.
module tb_box_readback20;
    logic        CLOCK_50 = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  x0 = '0;
    logic [8:0]  y0 = '0;
    logic [8:0]  bg_color = '0;
    logic [16:0] mem_addr;
    logic        mem_rd;
    logic [8:0]  mem_rdata;
    logic        busy, done, occupied;
    logic [8:0]  hit_count;
    logic [9:0]  first_x;
    logic [8:0]  first_y;

    int passed = 0, total = 0;
    logic [8:0] fb [0:76799];

`ifdef BOX_READBACK_FIRST_HIT_EN
    localparam bit FH = 1'b1;
`else
    localparam bit FH = 1'b0;
`endif

    box_readback20 dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .x0(x0), .y0(y0),
        .bg_color(bg_color), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .occupied(occupied), .hit_count(hit_count),
        .first_x(first_x), .first_y(first_y)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50)
        mem_rdata <= (mem_rd && mem_addr < 17'd76800) ? fb[mem_addr] : 9'h1ff;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // model: m_k is the cycle number since the accepted start (0 = idle)
    int m_k = 0, m_x0 = 0, m_y0 = 0, m_bg = 0;
    int m_hits = 0, m_fx = 0, m_fy = 0;
    int o_hits = 0, o_fx = 0, o_fy = 0;
    int rd_cnt = 0, first_addr = -1;
    bit armed = 0;

    function automatic void predict();
        m_hits = 0; m_fx = 0; m_fy = 0;
        for (int cy = 0; cy < 20; cy++)
            for (int cx = 0; cx < 20; cx++) begin
                int x, y;
                x = m_x0 + cx;
                y = m_y0 + cy;
                if (x < 320 && y < 240 && fb[y*320 + x] != 9'(m_bg)) begin
                    if (m_hits == 0) begin m_fx = x; m_fy = y; end
                    m_hits++;
                end
            end
    endfunction

    always @(posedge CLOCK_50) begin
        armed = 1'b1;
        if (resetn) begin
            m_k = 0; o_hits = 0; o_fx = 0; o_fy = 0;
        end else if (m_k == 0) begin
            if (start) begin
                m_k = 1; m_x0 = int'(x0); m_y0 = int'(y0); m_bg = int'(bg_color);
                predict();
                rd_cnt = 0; first_addr = -1;
            end
        end else if (m_k == 402) begin
            m_k = 0;
        end else begin
            m_k++;
            if (m_k == 402) begin o_hits = m_hits; o_fx = m_fx; o_fy = m_fy; end
        end
    end

    always @(negedge CLOCK_50) begin : cmp
        int p, x, y;
        bit e_rd;
        if (armed) begin
            p = m_k - 1;
            x = m_x0 + p % 20;
            y = m_y0 + p / 20;
            e_rd = m_k >= 1 && m_k <= 400 && x < 320 && y < 240;
            chk("busy", busy, m_k != 0);
            chk("done", done, m_k == 402);
            chk("mem_rd", mem_rd, e_rd);
            if (e_rd) begin
                chk("mem_addr", mem_addr, y*320 + x);
                rd_cnt++;
                if (first_addr < 0) first_addr = int'(mem_addr);
            end
            if (m_k == 0 || m_k == 402) begin
                chk("occupied", occupied, o_hits != 0);
                chk("hit_count", hit_count, o_hits);
                chk("first_x", first_x, FH ? o_fx : 0);
                chk("first_y", first_y, FH ? o_fy : 0);
            end
        end
    end

    task automatic box_fill(input int x, input int y, input logic [8:0] c);
        for (int cy = 0; cy < 20; cy++)
            for (int cx = 0; cx < 20; cx++)
                if (x + cx < 320 && y + cy < 240) fb[(y+cy)*320 + x + cx] = c;
    endtask

    task automatic fb_clear();
        for (int i = 0; i < 76800; i++) fb[i] = '0;
    endtask

    task automatic run_scan(input int x, input int y, input int bg, output int cyc);
        bit ok;
        @(negedge CLOCK_50);
        x0 = 10'(x); y0 = 9'(y); bg_color = 9'(bg); start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        ok = 1'b0;
        cyc = -1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge CLOCK_50);
            ok = done;
            if (ok) cyc = i + 2;
        end
        chk("done_seen", ok, 1);
    endtask

    initial begin
        int cyc;
        fb_clear();
        repeat (2) @(negedge CLOCK_50);
        chk("rst_busy", busy, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_addr", mem_addr, 0);
        resetn = 1'b0;

        run_scan(50, 40, 0, cyc);
        chk("empty_done_cycle", cyc, 402);
        chk("empty_occupied", occupied, 0);
        chk("empty_hits", hit_count, 0);
        chk("empty_rd_count", rd_cnt, 400);
        chk("empty_first_addr", first_addr, 12850);

        box_fill(50, 40, 9'b111_000_000);
        run_scan(50, 40, 0, cyc);
        @(negedge CLOCK_50);
        chk("drawn_occupied", occupied, 1);
        chk("drawn_hits", hit_count, 400);
`ifdef BOX_READBACK_FIRST_HIT_EN
        chk("drawn_first_x", first_x, 50);
        chk("drawn_first_y", first_y, 40);
`endif

        fb_clear();
        box_fill(60, 50, 9'b111_000_000);
        run_scan(50, 40, 0, cyc);
        chk("partial_hits", hit_count, 100);
`ifdef BOX_READBACK_FIRST_HIT_EN
        chk("partial_first_x", first_x, 60);
        chk("partial_first_y", first_y, 50);
`endif

        fb_clear();
        box_fill(310, 230, 9'b111_000_000);
        run_scan(310, 230, 0, cyc);
        chk("edge_rd_count", rd_cnt, 100);
        chk("edge_hits", hit_count, 100);
        run_scan(310, 230, 9'b111_000_000, cyc);
        chk("edge_bg_hits", hit_count, 0);
        chk("edge_bg_occupied", occupied, 0);

        @(negedge CLOCK_50);
        x0 = 10'd0; y0 = 9'd0; bg_color = 9'd0; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (98) @(negedge CLOCK_50);
        x0 = 10'd100; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        chk("restart_ignored_busy", busy, 1);
        repeat (99) @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        resetn = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_hits", hit_count, 0);
        run_scan(305, 225, 0, cyc);
        chk("after_reset_done_cycle", cyc, 402);
        chk("after_reset_hits", hit_count, 100);
        repeat (3) @(negedge CLOCK_50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/box_readback20.md
BOX_READBACK20 -- requirements
Module: box_readback20

Interface
REQ-001 Parameters SHALL be:
- BOX, default 20, box edge in pixels.
- H_RES, default 320, framebuffer width.
- V_RES, default 240, framebuffer height.
REQ-002 Ports SHALL be:
- CLOCK_50  in  1  sole clock, all logic on rising edge.
- resetn  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle request to scan a box.
- x0  in  10  box top-left X.
- y0  in  9  box top-left Y.
- bg_color  in  9  background colour (RGB 3:3:3).
- mem_addr  out  17  framebuffer read address.
- mem_rd  out  1  read strobe.
- mem_rdata  in  9  read data, valid exactly 1 cycle after the matching mem_rd.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse, results valid.
- occupied  out  1  at least one box pixel differs from bg_color.
- hit_count  out  9  number of differing pixels, 0..400.
- first_x  out  10  X of the first differing pixel (macro-gated, see REQ-019).
- first_y  out  9  Y of the first differing pixel (macro-gated, see REQ-019).

Function
REQ-003 The block SHALL be the read-side counterpart of the box draw engine: it scans a BOX x BOX region of the same framebuffer and reports whether the region is occupied.
REQ-004 The FSM SHALL have exactly these states: IDLE, READ, DRAIN, DONE.
REQ-005 In IDLE, start=1 SHALL latch x0, y0 and bg_color, clear hit_count, occupied and first_x/first_y, zero the column/row counters cx/cy, and enter READ on the next cycle.
REQ-006 In READ, the block SHALL visit one pixel per cycle in row-major order (cx 0..BOX-1 inner, cy 0..BOX-1 outer), for exactly BOX*BOX = 400 cycles.
REQ-007 For each visited pixel, mem_addr SHALL be (y0+cy)*H_RES + (x0+cx), truncated to 17 bits.
REQ-008 A pixel SHALL be on-screen only when the 11-bit sum x0+cx < H_RES and the 10-bit sum y0+cy < V_RES.
REQ-009 For an on-screen pixel, mem_rd SHALL be 1 in that cycle. For an off-screen pixel, mem_rd SHALL be 0, no read is issued, and the pixel counts as background.
REQ-010 The cycle after each mem_rd=1, the block SHALL compare mem_rdata with the latched bg_color. On inequality it SHALL increment hit_count and set occupied.
REQ-011 After the 400th visit the FSM SHALL enter DRAIN for one cycle to consume the final read, then enter DONE.
REQ-012 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-013 Latency: with start sampled at cycle 0, the first mem_rd SHALL occur at cycle 1 and done SHALL be 1 at cycle 402.
REQ-014 busy SHALL be 1 in READ, DRAIN and DONE, and 0 in IDLE.
REQ-015 start SHALL be ignored while busy=1; no restart and no effect on the latched inputs.
REQ-016 occupied, hit_count, first_x and first_y SHALL hold their values from done until the next accepted start.
REQ-017 mem_addr SHALL be don't-care whenever mem_rd=0.

Reset
REQ-018 resetn=1 at a clock edge SHALL force, on that same edge:
- state to IDLE, aborting any scan with no done pulse;
- mem_rd, busy and done to 0;
- occupied to 0, hit_count to 0;
- mem_addr, first_x and first_y to 0.
A read in flight at reset SHALL be discarded.

Configuration
REQ-019 Macro BOX_READBACK_FIRST_HIT_EN SHALL control the first-hit outputs.
- Defined: first_x and first_y capture the absolute coordinates (x0+cx, y0+cy) of the first differing pixel in scan order, and stay unchanged for later hits in the same scan.
- Undefined: first_x and first_y are tied to 0, and no capture registers are synthesized.

Verification
REQ-020 Empty region: framebuffer all bg_color=9'b000_000_000, start with x0=50, y0=40 -> done at cycle 402, occupied=0, hit_count=0, 400 mem_rd pulses, first address 12850.
REQ-021 Drawn box: 20x20 red (9'b111_000_000) box drawn at (50,40), scan the same origin -> occupied=1, hit_count=400, first_x=50, first_y=40 (macro defined).
REQ-022 Partial overlap: red box drawn at (60,50), scan at (50,40) -> hit_count=100, first_x=60, first_y=50.
REQ-023 Edge clipping: scan at x0=310, y0=230 -> exactly 100 mem_rd pulses, no address at or above 76800, hit_count counts only on-screen pixels.
REQ-024 Protocol: start pulsed again at cycle 100 -> ignored; resetn=1 at cycle 200 -> busy=0, no done pulse; a new start after reset completes normally.
